// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and decode helpers for the VGA timing generator.
package vga_timing_pkg;

  // Counter width used for both the horizontal and the vertical coordinate.
  localparam int CNT_W     = 10;
  // Largest total either counter can represent with CNT_W bits.
  localparam int MAX_TOTAL = 1 << CNT_W;

  // 640x480 @ 60 Hz timing, 25 MHz pixel clock.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Derived totals and sync windows (start inclusive, end exclusive).
  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // True when lo <= v < hi. Compared in 32 bits so an end position equal
  // to MAX_TOTAL still works.
  function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Modulo-N counter with enable, terminal-count flag and look-ahead next value.
module vga_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_tc
);

  localparam logic [W-1:0] L_MAX = W'(N - 1);

  logic [W-1:0] r_count;
  logic         w_at_max;

  // Next value and wrap flag; o_next is what r_count holds after the next edge.
  always_comb begin
    w_at_max = (r_count == L_MAX);
    o_tc     = i_en && w_at_max;
    o_next   = r_count;
    if (i_en) begin
      o_next = w_at_max ? '0 : r_count + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= o_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator: pixel/line counters plus registered video_on and sync decode.
module vga_controller
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS       = H_ACTIVE + H_FP;
  localparam int H_SE       = H_SS + H_SYNC;
  localparam int V_SS       = V_ACTIVE + V_FP;
  localparam int V_SE       = V_SS + V_SYNC;

  // Totals must fit the counter width; stop elaboration otherwise.
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_totals
    $fatal(1, "vga_controller: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
  end

  logic [CNT_W-1:0] w_hcount;
  logic [CNT_W-1:0] w_hnext;
  logic             w_h_tc;
  logic [CNT_W-1:0] w_vcount;
  logic [CNT_W-1:0] w_vnext;
  logic             w_v_tc_unused;

  logic w_video_on_next;
  logic w_hsync_next;
  logic w_vsync_next;

  logic r_video_on;
  logic r_hsync;
  logic r_vsync;

  vga_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
    .i_clk   (pclk),
    .i_rst_n (rst),
    .i_en    (1'b1),
    .o_count (w_hcount),
    .o_next  (w_hnext),
    .o_tc    (w_h_tc)
  );

  // Vertical counter advances only on the horizontal wrap.
  vga_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
    .i_clk   (pclk),
    .i_rst_n (rst),
    .i_en    (w_h_tc),
    .o_count (w_vcount),
    .o_next  (w_vnext),
    .o_tc    (w_v_tc_unused)
  );

  // Decode from the next counter values so the registered flags line up with x/y.
  always_comb begin
    w_video_on_next = in_window(w_hnext, 0, H_ACTIVE) && in_window(w_vnext, 0, V_ACTIVE);
    w_hsync_next    = in_window(w_hnext, H_SS, H_SE) ? SYNC_POL : ~SYNC_POL;
    w_vsync_next    = in_window(w_vnext, V_SS, V_SE) ? SYNC_POL : ~SYNC_POL;
  end

  // Output registers; syncs idle at the deasserted level during reset.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_video_on <= 1'b0;
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
    end else begin
      r_video_on <= w_video_on_next;
      r_hsync    <= w_hsync_next;
      r_vsync    <= w_vsync_next;
    end
  end

  assign x        = w_hcount;
  assign y        = w_vcount;
  assign video_on = r_video_on;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;

endmodule

// File: tb/tb_vga_controller.sv
// Self-checking bench: full-size instance for line timing, shrunk instance
// (active-high syncs) for whole frames, random asynchronous reset pulses.
module tb_vga_controller;
  import vga_timing_pkg::*;

  // Instance A: real 640x480 timing.
  localparam int A_HT = 640 + 16 + 96 + 48;   // 800
  localparam int A_VT = 480 + 10 + 2 + 33;    // 525
  // Instance B: tiny timing so full frames fit the run.
  localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VA = 4, B_VF = 1, B_VS = 2, B_VB = 1;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;   // 15
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;   // 8

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic [9:0] ax, ay, bx, by;
  logic       avo, ahs, avs, bvo, bhs, bvs;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  int k        = 0;   // clock edges since reset release

  always #20 pclk = ~pclk;

  vga_controller dut_a (
    .pclk(pclk), .rst(rst), .x(ax), .y(ay),
    .video_on(avo), .hsync(ahs), .vsync(avs)
  );

  vga_controller #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .SYNC_POL(1'b1)
  ) dut_b (
    .pclk(pclk), .rst(rst), .x(bx), .y(by),
    .video_on(bvo), .hsync(bhs), .vsync(bvs)
  );

  // Edge count since release; this is all the model needs.
  always @(posedge pclk or negedge rst) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  // Expected {x, y, video_on, hsync, vsync} after kk edges out of reset.
  function automatic logic [22:0] expect_out(input int kk, input logic rlvl,
      input int ht, input int vt, input int ha, input int va,
      input int hs0, input int hs1, input int vs0, input int vs1, input logic pol);
    int   ex, ey;
    logic vo, hs, vs;
    if (!rlvl || kk == 0) return {20'd0, 1'b0, ~pol, ~pol};
    ex = kk % ht;
    ey = (kk / ht) % vt;
    vo = (ex < ha) && (ey < va);
    hs = (ex >= hs0 && ex < hs1) ? pol : ~pol;
    vs = (ey >= vs0 && ey < vs1) ? pol : ~pol;
    return {ex[9:0], ey[9:0], vo, hs, vs};
  endfunction

  task automatic check_vec(input string nm, input logic [22:0] act, input logic [22:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s k=%0d actual x=%0d y=%0d vo=%b hs=%b vs=%b required x=%0d y=%0d vo=%b hs=%b vs=%b",
               nm, k, act[22:13], act[12:3], act[2], act[1], act[0],
               req[22:13], req[12:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge pclk) begin
    if (cmp_en) begin
      check_vec("model_a", {ax, ay, avo, ahs, avs},
                expect_out(k, rst, A_HT, A_VT, 640, 480, 656, 752, 490, 492, 1'b0));
      check_vec("model_b", {bx, by, bvo, bhs, bvs},
                expect_out(k, rst, B_HT, B_VT, B_HA, B_VA, B_HA + B_HF, B_HA + B_HF + B_HS,
                           B_VA + B_VF, B_VA + B_VF + B_VS, 1'b1));
    end
  end

  initial begin
    int hs_low;
    int vs_on;
    int vo_on;
    int first_wrap;
    int wrap_gap;

    // Reset hold, roughly 100 ns.
    #1 rst = 1'b0;
    #1 cmp_en = 1'b1;
    #48;
    check_vec("reset_a", {ax, ay, avo, ahs, avs}, {20'd0, 1'b0, 1'b1, 1'b1});
    check_vec("reset_b", {bx, by, bvo, bhs, bvs}, {20'd0, 1'b0, 1'b0, 1'b0});
    #55 rst = 1'b1;

    // First edge after release.
    @(posedge pclk); #1;
    check_vec("first_edge_a", {ax, ay, avo, ahs, avs}, {10'd1, 10'd0, 1'b1, 1'b1, 1'b1});
    check_vec("first_edge_b", {bx, by, bvo, bhs, bvs}, {10'd1, 10'd0, 1'b1, 1'b0, 1'b0});

    // Line timing landmarks on instance A.
    hs_low = 0;
    for (int c = 0; c < 1700; c++) begin
      @(negedge pclk);
      if (k >= 800 && k < 1600 && ahs == 1'b0) hs_low++;
      case (k)
        639: check_int("vo_at_639", int'(avo), 1);
        640: begin check_int("vo_at_640", int'(avo), 0); check_int("x_at_640", int'(ax), 640); end
        655: check_int("hs_at_655", int'(ahs), 1);
        656: check_int("hs_at_656", int'(ahs), 0);
        751: check_int("hs_at_751", int'(ahs), 0);
        752: check_int("hs_at_752", int'(ahs), 1);
        799: check_vec("line_end", {ax, ay, avo, ahs, avs}, {10'd799, 10'd0, 1'b0, 1'b1, 1'b1});
        800: check_vec("line_wrap", {ax, ay, avo, ahs, avs}, {10'd0, 10'd1, 1'b1, 1'b1, 1'b1});
        default: ;
      endcase
    end
    check_int("hsync_low_cycles", hs_low, 96);

    // Mid-line asynchronous reset at x=300, y=2.
    while (k < 1900) @(negedge pclk);
    check_int("pre_reset_x", int'(ax), 300);
    #5 rst = 1'b0;
    #5;
    check_vec("async_reset_a", {ax, ay, avo, ahs, avs}, {20'd0, 1'b0, 1'b1, 1'b1});
    check_vec("async_reset_b", {bx, by, bvo, bhs, bvs}, {20'd0, 1'b0, 1'b0, 1'b0});
    @(negedge pclk); #3 rst = 1'b1;
    @(posedge pclk); #1;
    check_int("resume_x", int'(ax), 1);

    // Whole frames on instance B: sync/active counts and wrap period.
    vs_on = 0; vo_on = 0; first_wrap = -1; wrap_gap = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge pclk);
      if (k >= B_HT * B_VT && k < 2 * B_HT * B_VT) begin
        if (bvs) vs_on++;
        if (bvo) vo_on++;
      end
      if (bx == 10'd0 && by == 10'd0 && k > 0) begin
        if (first_wrap < 0) first_wrap = k;
        else if (wrap_gap < 0) wrap_gap = k - first_wrap;
      end
    end
    check_int("b_vsync_cycles", vs_on, 30);
    check_int("b_video_on_cycles", vo_on, 32);
    check_int("b_frame_period", wrap_gap, 120);

    // Random run lengths with reset pulses at random phases.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 3000)) @(negedge pclk);
      #($urandom_range(1, 15)) rst = 1'b0;
      #1;
      check_vec("rand_reset_a", {ax, ay, avo, ahs, avs}, {20'd0, 1'b0, 1'b1, 1'b1});
      repeat ($urandom_range(0, 2)) @(negedge pclk);
      @(negedge pclk);
      #($urandom_range(1, 15)) rst = 1'b1;
    end
    repeat (50) @(negedge pclk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
